// File: rtl/mcu_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_bridge_pkg
//  Purpose  : Shared types and constants for the cartridge-bus to MCU SPI
//             command bridge: engine state encoding, command codes, the
//             invalid-command mask and the RegCtrl bit layout.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mcu_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOWER_CS = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RAISE_CS = 3'd4
  } spi_state_t;

  typedef logic [3:0] cmd_t;

  // Bit 0 of every command selects the direction: 1 = read, 0 = write.
  localparam cmd_t CMD_RESET     = 4'h0;
  localparam cmd_t CMD_STATUS_RD = 4'h1;
  localparam cmd_t CMD_CFG_WR    = 4'h2;
  localparam cmd_t CMD_CFG_RD    = 4'h3;
  localparam cmd_t CMD_TIME_WR   = 4'h4;
  localparam cmd_t CMD_TIME_RD   = 4'h5;
  localparam cmd_t CMD_ALARM_WR  = 4'h6;
  localparam cmd_t CMD_ALARM_RD  = 4'h7;
  localparam cmd_t CMD_DATA_WR   = 4'h8;
  localparam cmd_t CMD_DATA_RD   = 4'h9;
  localparam cmd_t CMD_NOP_WR    = 4'hA;
  localparam cmd_t CMD_NOP       = 4'hB;

  // Codes 0xC..0xF (Cmd[3:1] = 6 or 7) are reserved and refused at start.
  localparam cmd_t INVALID_CMD_MASK = 4'hC;

  localparam int CTRL_READY_BIT   = 7;
  localparam int CTRL_RXVALID_BIT = 6;
  localparam int CTRL_TXFULL_BIT  = 5;
  localparam int CTRL_BUSY_BIT    = 4;
  localparam int CTRL_CMD_MSB     = 3;

  function automatic logic is_invalid_cmd(input cmd_t c);
    return (c & INVALID_CMD_MASK) == INVALID_CMD_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_byte_fifo
//  Purpose  : Small synchronous byte FIFO with first-word-fall-through head.
//             A push into a full FIFO is accepted only when a pop happens in
//             the same cycle (the pop frees the slot). Pop on empty is ignored.
//  Ports    : clk, rst_n (async active-low), flush (sync clear),
//             push/push_data, pop, full, empty, head
//  Params   : DEPTH - number of entries (power of 2, >= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module mcu_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/mcu_spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : mcu_spi_cmd_bridge
//  Purpose  : Cartridge-bus to MCU SPI command engine. The host programs a
//             payload length and a command, streams payload bytes through a
//             TX FIFO (write direction) or collects reply bytes from an RX
//             FIFO (read direction). A frame is: command byte {4'hF,Cmd},
//             then LEN payload bytes, each preceded by one stretch cycle.
//  Ports    : SClk, nReset (async active-low)
//             bus  : BusWrite, BusRead, SelData, SelCtrl, SelLen, WriteData,
//                    RegData (RX head / 8'hFF), RegCtrl
//                    {Ready,RxValid,TxFull,Busy|Invalid,Cmd}, RegLen
//             MCU  : SPIDi, SPIDo, nMCUSel, MCUReady, SPIClkRunning,
//                    SPIClkStretch
//  Params   : FIFO_DEPTH (per FIFO), MAX_LEN (LEN clamp)
//  Config   : MCU_READY_HANDSHAKE_EN - when defined, WAIT and RAISE_CS also
//             wait for a synchronised falling edge of MCUReady.
//  Revision : 1.0 - initial release
// ============================================================================
module mcu_spi_cmd_bridge #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LEN    = 16
) (
  input  logic       SClk,
  input  logic       nReset,
  input  logic       BusWrite,
  input  logic       BusRead,
  input  logic       SelData,
  input  logic       SelCtrl,
  input  logic       SelLen,
  input  logic [7:0] WriteData,
  output logic [7:0] RegData,
  output logic [7:0] RegCtrl,
  output logic [7:0] RegLen,
  input  logic       SPIDi,
  output logic       SPIDo,
  output logic       nMCUSel,
  input  logic       MCUReady,
  output logic       SPIClkRunning,
  output logic       SPIClkStretch
);

  import mcu_bridge_pkg::*;

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  spi_state_t       state;
  spi_state_t       state_nxt;
  cmd_t             cmd;
  logic             ready;
  logic             busy;
  logic             invalid;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] pay_cnt;   // payload bytes started in this frame
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             cs_n;

  logic       wr_ctrl, wr_len, wr_data, rd_data;
  logic       start_req, start_bad, start_ok, flush;
  logic       dir_rd, hs_ok, wait_go, raise_go;
  logic       tx_pop_eng, rx_push_eng;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;

  // ---------------------------------------------------------------- bus decode
  // Control and length registers are frozen for the whole frame.
  assign wr_ctrl   = BusWrite & SelCtrl & ~busy;
  assign wr_len    = BusWrite & SelLen  & ~busy;
  assign wr_data   = BusWrite & SelData;
  assign rd_data   = BusRead  & SelData;
  assign start_req = wr_ctrl & WriteData[4];
  assign start_bad = start_req & is_invalid_cmd(WriteData[3:0]);
  assign start_ok  = start_req & ~start_bad;
  assign flush     = wr_ctrl & WriteData[5];
  assign dir_rd    = cmd[0];

  // ---------------------------------------------------------- MCU handshake
`ifdef MCU_READY_HANDSHAKE_EN
  logic [2:0] mr_sync;
  logic       mr_fall;
  logic       fall_seen;

  assign mr_fall = mr_sync[2] & ~mr_sync[1];
  // A falling edge seen while still shifting is remembered so it is not lost.
  assign hs_ok   = fall_seen | mr_fall;

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      mr_sync   <= 3'b000;
      fall_seen <= 1'b0;
    end else begin
      mr_sync <= {mr_sync[1:0], MCUReady};
      if (state == ST_LOWER_CS || wait_go || raise_go) fall_seen <= 1'b0;
      else if (mr_fall)                                 fall_seen <= 1'b1;
    end
  end
`else
  logic unused_mcu_ready;
  assign unused_mcu_ready = MCUReady;
  assign hs_ok            = 1'b1;
`endif

  // ----------------------------------------------------------- engine strobes
  // Read direction refuses to start a byte while RX is full, so the reply of
  // that byte always has a slot when it completes.
  assign wait_go     = (state == ST_WAIT) & (dir_rd ? ~rx_full : ~tx_empty) & hs_ok;
  assign raise_go    = (state == ST_RAISE_CS) & hs_ok;
  assign tx_pop_eng  = wait_go & ~dir_rd;
  // The reply clocked in during the command byte is discarded.
  assign rx_push_eng = (state == ST_SHIFT) & (bit_cnt == 3'd7) & dir_rd & (pay_cnt != '0);

  // ---------------------------------------------------------------- FSM comb
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (busy) state_nxt = ST_LOWER_CS;
      ST_LOWER_CS: state_nxt = ST_SHIFT;
      ST_SHIFT:    if (bit_cnt == 3'd7) state_nxt = (pay_cnt == len) ? ST_RAISE_CS : ST_WAIT;
      ST_WAIT:     if (wait_go) state_nxt = ST_SHIFT;
      ST_RAISE_CS: if (raise_go) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM seq
  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      cmd     <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      invalid <= 1'b0;
      len     <= '0;
      pay_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= 8'hFF;
      cs_n    <= 1'b1;
    end else begin
      state <= state_nxt;
      // Chip select follows the next state so it drops entering SHIFT and
      // rises on the same edge that enters RAISE_CS.
      cs_n  <= ~((state_nxt == ST_SHIFT) || (state_nxt == ST_WAIT));

      if (wr_ctrl) begin
        cmd     <= WriteData[3:0];
        invalid <= start_bad;
        if (start_ok) begin
          ready <= 1'b0;
          busy  <= 1'b1;
        end
      end

      if (wr_len) begin
        len <= (WriteData > 8'(MAX_LEN)) ? LEN_W'(MAX_LEN) : WriteData[LEN_W-1:0];
      end

      case (state)
        ST_LOWER_CS: begin
          shreg   <= {4'hF, cmd};
          bit_cnt <= '0;
          pay_cnt <= '0;
        end
        ST_SHIFT: begin
          shreg   <= {shreg[6:0], SPIDi};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_WAIT: begin
          if (wait_go) begin
            shreg   <= dir_rd ? 8'hFF : tx_head;
            bit_cnt <= '0;
            pay_cnt <= pay_cnt + LEN_W'(1);
          end
        end
        ST_RAISE_CS: begin
          if (raise_go) begin
            ready <= 1'b1;
            busy  <= 1'b0;
            shreg <= 8'hFF;  // idle MOSI high between frames
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FIFOs
  mcu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (SClk),
    .rst_n     (nReset),
    .flush     (flush),
    .push      (wr_data),
    .push_data (WriteData),
    .pop       (tx_pop_eng),
    .full      (tx_full),
    .empty     (tx_empty),
    .head      (tx_head)
  );

  mcu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (SClk),
    .rst_n     (nReset),
    .flush     (flush),
    .push      (rx_push_eng),
    .push_data ({shreg[6:0], SPIDi}),
    .pop       (rd_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .head      (rx_head)
  );

  // ---------------------------------------------------------------- outputs
  always_comb begin
    RegCtrl                   = '0;
    RegCtrl[CTRL_READY_BIT]   = ready;
    RegCtrl[CTRL_RXVALID_BIT] = ~rx_empty;
    RegCtrl[CTRL_TXFULL_BIT]  = tx_full;
    RegCtrl[CTRL_BUSY_BIT]    = busy | invalid;
    RegCtrl[CTRL_CMD_MSB:0]   = cmd;
  end

  assign RegData       = rx_empty ? 8'hFF : rx_head;
  assign RegLen        = {{(8-LEN_W){1'b0}}, len};
  assign SPIDo         = shreg[7];
  assign nMCUSel       = cs_n;
  assign SPIClkRunning = (state == ST_SHIFT);
  assign SPIClkStretch = (state == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_cmd_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcu_spi_cmd_bridge
//  Purpose  : Self-checking bench for mcu_spi_cmd_bridge: a register-access
//             vector table plus directed frame sequences (write, read, TX
//             stall, frozen registers, reset mid-frame). An MCU model logs
//             MOSI bytes and serves MISO bytes from a table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_cmd_bridge;

  logic       SClk = 1'b0;
  logic       nReset = 1'b0;
  logic       BusWrite = 1'b0, BusRead = 1'b0;
  logic       SelData = 1'b0, SelCtrl = 1'b0, SelLen = 1'b0;
  logic [7:0] WriteData = 8'h00;
  logic [7:0] RegData, RegCtrl, RegLen;
  logic       SPIDi = 1'b1;
  logic       SPIDo, nMCUSel, SPIClkRunning, SPIClkStretch;
  logic       MCUReady = 1'b0;

  mcu_spi_cmd_bridge #(.FIFO_DEPTH(8), .MAX_LEN(16)) dut (
    .SClk          (SClk),
    .nReset        (nReset),
    .BusWrite      (BusWrite),
    .BusRead       (BusRead),
    .SelData       (SelData),
    .SelCtrl       (SelCtrl),
    .SelLen        (SelLen),
    .WriteData     (WriteData),
    .RegData       (RegData),
    .RegCtrl       (RegCtrl),
    .RegLen        (RegLen),
    .SPIDi         (SPIDi),
    .SPIDo         (SPIDo),
    .nMCUSel       (nMCUSel),
    .MCUReady      (MCUReady),
    .SPIClkRunning (SPIClkRunning),
    .SPIClkStretch (SPIClkStretch)
  );

  always #5 SClk = ~SClk;

  int n_checks = 0;
  int n_errors = 0;

  // ------------------------------------------------------------ MCU model
  logic [7:0] miso_tbl [0:7];
  logic [7:0] mosi_log [0:255];
  int         mosi_cnt   = 0;
  int         cs_low_cnt = 0;
  int         pos = 0, bitn = 0;
  logic [7:0] mosi_sr = 8'h00;

  always @(negedge SClk) begin
    if (nMCUSel) begin
      pos   = 0;
      bitn  = 0;
      SPIDi = 1'b1;
    end else if (SPIClkRunning) begin
      mosi_sr = {mosi_sr[6:0], SPIDo};
      SPIDi   = miso_tbl[pos & 7][7 - bitn];
      if (bitn == 7) begin
        mosi_log[mosi_cnt & 255] = mosi_sr;
        mosi_cnt = mosi_cnt + 1;
        pos  = pos + 1;
        bitn = 0;
      end else begin
        bitn = bitn + 1;
      end
    end
    if (!nMCUSel) cs_low_cnt = cs_low_cnt + 1;
  end

  // ------------------------------------------------------------ helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // sel: 0 = data, 1 = ctrl, 2 = len
  task automatic bus_wr(input logic [1:0] sel, input logic [7:0] d);
    @(negedge SClk);
    WriteData = d;
    SelData   = (sel == 2'd0);
    SelCtrl   = (sel == 2'd1);
    SelLen    = (sel == 2'd2);
    BusWrite  = 1'b1;
    @(negedge SClk);
    BusWrite = 1'b0;
    SelData  = 1'b0;
    SelCtrl  = 1'b0;
    SelLen   = 1'b0;
  endtask

  task automatic bus_rd();
    @(negedge SClk);
    SelData = 1'b1;
    BusRead = 1'b1;
    @(negedge SClk);
    BusRead = 1'b0;
    SelData = 1'b0;
  endtask

  // Start edge is N; returns just after N with the start already checked.
  task automatic start_xfer(input logic [7:0] c);
    @(negedge SClk);
    WriteData = c;
    SelCtrl   = 1'b1;
    BusWrite  = 1'b1;
    @(posedge SClk);
    #1;
    chk("start_ctrl", RegCtrl, {4'b0001, c[3:0]});
    chk("start_cs_high", nMCUSel, 1'b1);
    @(negedge SClk);
    BusWrite = 1'b0;
    SelCtrl  = 1'b0;
  endtask

  // Counts edges after N until Ready is visible.
  task automatic wait_done(input int limit, output int cyc);
    logic done;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < limit) begin
      @(posedge SClk);
      #1;
      cyc++;
      if (RegCtrl[7]) done = 1'b1;
    end
    chk("xfer_done", done, 1'b1);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_len;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int cyc;
    int base;
    int cs0;
    logic got;

    // ---------------- register vectors: {sel, wdata, RegCtrl, RegLen}
    vecs[0]  = '{2'd2, 8'h05, 8'h00, 8'h05};
    vecs[1]  = '{2'd2, 8'hC8, 8'h00, 8'h10};  // clamp to MAX_LEN
    vecs[2]  = '{2'd2, 8'h10, 8'h00, 8'h10};
    vecs[3]  = '{2'd2, 8'h11, 8'h00, 8'h10};  // MAX_LEN+1
    vecs[4]  = '{2'd2, 8'h00, 8'h00, 8'h00};
    vecs[5]  = '{2'd1, 8'h1C, 8'h1C, 8'h00};  // invalid start
    vecs[6]  = '{2'd1, 8'h0A, 8'h0A, 8'h00};  // clears Invalid
    vecs[7]  = '{2'd1, 8'h1E, 8'h1E, 8'h00};
    vecs[8]  = '{2'd1, 8'h05, 8'h05, 8'h00};
    vecs[9]  = '{2'd1, 8'h1D, 8'h1D, 8'h00};
    vecs[10] = '{2'd1, 8'h20, 8'h00, 8'h00};  // flush, cmd 0
    vecs[11] = '{2'd2, 8'h03, 8'h00, 8'h03};

    for (int i = 0; i < 8; i++) miso_tbl[i] = 8'hFF;

    // ---------------- reset
    repeat (3) @(negedge SClk);
    chk("rst_ctrl", RegCtrl, 8'h00);
    chk("rst_len", RegLen, 8'h00);
    chk("rst_data", RegData, 8'hFF);
    chk("rst_cs", nMCUSel, 1'b1);
    chk("rst_mosi", SPIDo, 1'b1);
    chk("rst_run", {SPIClkRunning, SPIClkStretch}, 2'b00);
    nReset = 1'b1;

    // ---------------- table
    for (int i = 0; i < 12; i++) begin
      bus_wr(vecs[i].sel, vecs[i].wdata);
      chk($sformatf("vec%0d_ctrl", i), RegCtrl, vecs[i].exp_ctrl);
      chk($sformatf("vec%0d_len", i), RegLen, vecs[i].exp_len);
      chk($sformatf("vec%0d_cs", i), nMCUSel, 1'b1);
    end

    // ---------------- TX full and flush
    for (int i = 0; i < 8; i++) bus_wr(2'd0, 8'(i + 1));
    chk("txfull_set", RegCtrl, 8'h20);
    bus_wr(2'd0, 8'h99);
    chk("txfull_drop", RegCtrl, 8'h20);
    bus_wr(2'd1, 8'h20);
    chk("flush_ctrl", RegCtrl, 8'h00);

    // ---------------- write frame LEN=2
    bus_wr(2'd2, 8'h02);
    bus_wr(2'd0, 8'hA5);
    bus_wr(2'd0, 8'h3C);
    base = mosi_cnt;
    cs0  = cs_low_cnt;
    start_xfer(8'h12);
    wait_done(200, cyc);
    chk("wr_ready_latency", cyc, 29);
    chk("wr_nbytes", mosi_cnt - base, 3);
    chk("wr_mosi0", mosi_log[base & 255], 8'hF2);
    chk("wr_mosi1", mosi_log[(base + 1) & 255], 8'hA5);
    chk("wr_mosi2", mosi_log[(base + 2) & 255], 8'h3C);
    chk("wr_cs_low", cs_low_cnt - cs0, 26);
    chk("wr_ctrl_end", RegCtrl, 8'h82);
    chk("wr_cs_end", nMCUSel, 1'b1);

    // ---------------- read frame LEN=3
    miso_tbl[0] = 8'h00; miso_tbl[1] = 8'h11;
    miso_tbl[2] = 8'h22; miso_tbl[3] = 8'h33;
    bus_wr(2'd2, 8'h03);
    base = mosi_cnt;
    start_xfer(8'h13);
    wait_done(200, cyc);
    chk("rd_ready_latency", cyc, 38);
    chk("rd_mosi0", mosi_log[base & 255], 8'hF3);
    for (int i = 1; i < 4; i++)
      chk($sformatf("rd_mosi%0d", i), mosi_log[(base + i) & 255], 8'hFF);
    chk("rd_ctrl_end", RegCtrl, 8'hC3);
    for (int i = 1; i < 4; i++) begin
      @(negedge SClk);
      chk($sformatf("rd_pop%0d", i), RegData, {i[3:0], i[3:0]});
      bus_rd();
    end
    chk("rd_empty_data", RegData, 8'hFF);
    chk("rd_empty_ctrl", RegCtrl, 8'h83);

    // ---------------- TX stall
    bus_wr(2'd2, 8'h02);
    base = mosi_cnt;
    start_xfer(8'h12);
    repeat (30) @(posedge SClk);
    #1;
    chk("stall_cs", nMCUSel, 1'b0);
    chk("stall_stretch", {SPIClkStretch, SPIClkRunning}, 2'b10);
    chk("stall_nbytes", mosi_cnt - base, 1);
    bus_wr(2'd0, 8'h7E);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge SClk);
      #1;
      if (mosi_cnt - base == 2) got = 1'b1;
    end
    chk("stall_resume", got, 1'b1);
    chk("stall_mosi1", mosi_log[(base + 1) & 255], 8'h7E);
    repeat (3) @(posedge SClk);
    #1;
    chk("stall_again", SPIClkStretch, 1'b1);
    bus_wr(2'd0, 8'h81);
    wait_done(100, cyc);
    chk("stall_mosi2", mosi_log[(base + 2) & 255], 8'h81);
    chk("stall_ctrl_end", RegCtrl, 8'h82);

    // ---------------- ctrl/LEN frozen during frame
    bus_wr(2'd2, 8'h01);
    bus_wr(2'd0, 8'h55);
    base = mosi_cnt;
    start_xfer(8'h12);
    repeat (3) @(posedge SClk);
    bus_wr(2'd2, 8'h09);
    bus_wr(2'd1, 8'h05);
    chk("frz_len", RegLen, 8'h01);
    chk("frz_ctrl", RegCtrl, 8'h12);
    wait_done(100, cyc);
    chk("frz_mosi0", mosi_log[base & 255], 8'hF2);
    chk("frz_mosi1", mosi_log[(base + 1) & 255], 8'h55);
    chk("frz_ctrl_end", RegCtrl, 8'h82);

    // ---------------- reset mid-byte 2 of a read frame
    miso_tbl[0] = 8'h00; miso_tbl[1] = 8'hAA;
    miso_tbl[2] = 8'hBB; miso_tbl[3] = 8'hCC;
    bus_wr(2'd2, 8'h03);
    base = mosi_cnt;
    start_xfer(8'h13);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge SClk);
      #1;
      if (mosi_cnt - base == 2) got = 1'b1;
    end
    chk("mid_reached", got, 1'b1);
    repeat (4) @(posedge SClk);
    #1;
    chk("mid_rxvalid", RegCtrl[6], 1'b1);
    chk("mid_cs_low", nMCUSel, 1'b0);
    #2 nReset = 1'b0;
    #1;
    chk("arst_cs", nMCUSel, 1'b1);
    chk("arst_ctrl", RegCtrl, 8'h00);
    chk("arst_data", RegData, 8'hFF);
    @(negedge SClk);
    nReset = 1'b1;
    repeat (5) @(negedge SClk);
    chk("arst_no_ready", RegCtrl, 8'h00);
    chk("arst_cs_idle", nMCUSel, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
